// File: rtl/clock_pkg.sv
// Shared mode encoding for the digital clock: 16 state codes, all legal,
// plus helpers that classify a code and map an edit state to its display home.
package clock_pkg;

    typedef enum logic [3:0] {
        TIME_DISP         = 4'd0,
        DATE_DISP         = 4'd1,
        TIME_EDIT_SECOND  = 4'd2,
        TIME_EDIT_MINUTE  = 4'd3,
        TIME_EDIT_HOUR    = 4'd4,
        TIME_EDIT_DAY     = 4'd5,
        TIME_EDIT_MONTH   = 4'd6,
        TIME_EDIT_YEAR    = 4'd7,
        ALARM_DISP        = 4'd8,
        ALARM_EDIT_SECOND = 4'd9,
        ALARM_EDIT_MINUTE = 4'd10,
        ALARM_EDIT_HOUR   = 4'd11,
        TIMER_DISP        = 4'd12,
        TIMER_EDIT_SECOND = 4'd13,
        TIMER_EDIT_MINUTE = 4'd14,
        TIMER_EDIT_HOUR   = 4'd15
    } state_t;

    function automatic logic is_edit(input state_t s);
        return !(s inside {TIME_DISP, DATE_DISP, ALARM_DISP, TIMER_DISP});
    endfunction

    // Codes 0-7 belong to the time group, 8-11 alarm, 12-15 timer.
    function automatic state_t group_home(input state_t s);
        if (!s[3])      return TIME_DISP;
        else if (!s[2]) return ALARM_DISP;
        else            return TIMER_DISP;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sec_idle_timer.sv
// Seconds counter with synchronous clear; pulses `expired` for one cycle
// after the increment that lands on `limit`, then holds until cleared.
module sec_idle_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clr) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (inc && cnt != limit) begin
            cnt     <= cnt_nxt;
            expired <= (cnt_nxt == limit);
        end else begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer: button pulses -> display/edit state, edit pulses, commit/abort,
// edit inactivity timeout and alarm ring. Define CLOCK_MODE_AUTO_RETURN_EN to
// make non-time display states fall back to TIME_DISP after AUTO_RET_S idle ticks.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int EDIT_TIMEOUT_S = 30,
    parameter int RING_MAX_S     = 60
`ifdef CLOCK_MODE_AUTO_RETURN_EN
    , parameter int AUTO_RET_S   = 10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_p,
    input  logic       set_p,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       alarm_hit,
    output logic [3:0] state,
    output logic       edit_up,
    output logic       edit_down,
    output logic       commit_p,
    output logic       abort_p,
    output logic       ring
);

`ifdef CLOCK_MODE_AUTO_RETURN_EN
    localparam int IDLE_MAX = max_int(EDIT_TIMEOUT_S, AUTO_RET_S);
`else
    localparam int IDLE_MAX = EDIT_TIMEOUT_S;
`endif
    localparam int IDLE_W = $clog2(IDLE_MAX + 1);
    localparam int RING_W = $clog2(RING_MAX_S + 1);

    state_t            cur, nxt;
    logic              acc, up_n, dn_n, cm_n, ab_n;
    logic              any_p, in_edit, alarm_q, rise;
    logic              idle_exp, idle_inc, ring_exp;
    logic [IDLE_W-1:0] idle_lim;

    assign any_p   = mode_p | set_p | up_p | down_p;
    assign in_edit = is_edit(cur);
    assign rise    = alarm_hit & ~alarm_q;
    assign state   = cur;

`ifdef CLOCK_MODE_AUTO_RETURN_EN
    assign idle_inc = tick_1hz & (in_edit | (cur inside {DATE_DISP, ALARM_DISP, TIMER_DISP}));
    assign idle_lim = in_edit ? IDLE_W'(EDIT_TIMEOUT_S) : IDLE_W'(AUTO_RET_S);
`else
    assign idle_inc = tick_1hz & in_edit;
    assign idle_lim = IDLE_W'(EDIT_TIMEOUT_S);
`endif

    // Priority chain: ring-ack swallows everything, then mode, set, up, down,
    // and the idle timeout only acts when no pulse was accepted this cycle.
    always_comb begin
        nxt  = cur;
        acc  = 1'b0;
        up_n = 1'b0;
        dn_n = 1'b0;
        cm_n = 1'b0;
        ab_n = 1'b0;
        if (ring && any_p) begin
            acc = 1'b1;
        end else if (mode_p) begin
            acc = 1'b1;
            if (in_edit) begin
                nxt  = group_home(cur);
                ab_n = 1'b1;
            end else begin
                case (cur)
                    TIME_DISP:  nxt = DATE_DISP;
                    DATE_DISP:  nxt = ALARM_DISP;
                    ALARM_DISP: nxt = TIMER_DISP;
                    default:    nxt = TIME_DISP;
                endcase
            end
        end else if (set_p) begin
            acc = 1'b1;
            case (cur)
                TIME_DISP, DATE_DISP: nxt = TIME_EDIT_SECOND;
                ALARM_DISP:           nxt = ALARM_EDIT_SECOND;
                TIMER_DISP:           nxt = TIMER_EDIT_SECOND;
                TIME_EDIT_YEAR, ALARM_EDIT_HOUR, TIMER_EDIT_HOUR: begin
                    nxt  = group_home(cur);
                    cm_n = 1'b1;
                end
                default:              nxt = state_t'(cur + 4'd1);
            endcase
        end else if (up_p && in_edit) begin
            acc  = 1'b1;
            up_n = 1'b1;
        end else if (down_p && in_edit) begin
            acc  = 1'b1;
            dn_n = 1'b1;
        end else if (idle_exp) begin
            if (in_edit) begin
                nxt  = group_home(cur);
                ab_n = 1'b1;
            end else begin
                nxt  = TIME_DISP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= TIME_DISP;
            edit_up   <= 1'b0;
            edit_down <= 1'b0;
            commit_p  <= 1'b0;
            abort_p   <= 1'b0;
            ring      <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            cur       <= nxt;
            edit_up   <= up_n;
            edit_down <= dn_n;
            commit_p  <= cm_n;
            abort_p   <= ab_n;
            alarm_q   <= alarm_hit;
            if (rise)
                ring <= 1'b1;
            else if (ring && (any_p || ring_exp))
                ring <= 1'b0;
        end
    end

    sec_idle_timer #(.W(IDLE_W)) u_idle (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc | (nxt != cur)),
        .inc     (idle_inc),
        .limit   (idle_lim),
        .expired (idle_exp)
    );

    sec_idle_timer #(.W(RING_W)) u_ring (
        .clk     (clk),
        .rst     (rst),
        .clr     (rise | ~ring),
        .inc     (tick_1hz & ring),
        .limit   (RING_W'(RING_MAX_S)),
        .expired (ring_exp)
    );

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Top-level mode sequencer for the digital clock. It owns the 4-bit display/edit `state` bus that drives the LED interface. It converts single-cycle button pulses (mode/set/up/down) into state transitions and gated edit pulses. It also enforces an edit inactivity timeout and handles alarm silencing.

Parameters:
EDIT_TIMEOUT_S, 30, 1 Hz ticks with no accepted pulse before an edit state aborts.
RING_MAX_S, 60, ticks after which an unacknowledged ring self-silences.
AUTO_RET_S, 10, ticks before a non-time display returns to TIME_DISP (optional feature only).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick_1hz  in  1  one-cycle strobe, once per second
mode_p  in  1  mode button pulse, one cycle, active-high
set_p  in  1  set button pulse
up_p  in  1  up button pulse
down_p  in  1  down button pulse
alarm_hit  in  1  alarm match level from the time/alarm datapath
state  out  4  current mode, encoded as the shared state constants
edit_up  out  1  registered up pulse, asserted only in edit states
edit_down  out  1  registered down pulse, asserted only in edit states
commit_p  out  1  one-cycle pulse when an edit sequence completes via set
abort_p  out  1  one-cycle pulse when an edit sequence aborts (mode press or timeout)
ring  out  1  buzzer enable

Behaviour:
- Reset (async, immediate): state=TIME_DISP (0). All pulse outputs, ring, and both counters are 0.
- All outputs are registered. A response appears 1 cycle after the input pulse.
- Pulse priority within one cycle: ring-acknowledge > mode > set > up > down. Lower-priority pulses in the same cycle are dropped.
- Display ring on mode: TIME_DISP -> DATE_DISP -> ALARM_DISP -> TIMER_DISP -> TIME_DISP.
- Set from TIME_DISP or DATE_DISP -> TIME_EDIT_SECOND. Set then advances SECOND -> MINUTE -> HOUR -> DAY -> MONTH -> YEAR -> TIME_DISP, and commit_p fires on the final set.
- Set from ALARM_DISP -> ALARM_EDIT_SECOND -> MINUTE -> HOUR -> ALARM_DISP, with commit_p on the final set.
- Set from TIMER_DISP follows the same three-step chain through TIMER_EDIT_*, returning to TIMER_DISP, with commit_p on the final set.
- Mode in any edit state returns to that group's display state (TIME_EDIT_* -> TIME_DISP, ALARM_EDIT_* -> ALARM_DISP, TIMER_EDIT_* -> TIMER_DISP) and fires abort_p.
- up_p/down_p in an edit state produce edit_up/edit_down one cycle later. In display states they are swallowed.
- Idle counter: width clog2(EDIT_TIMEOUT_S+1).
  - Clears on any accepted pulse and on any state change.
  - Increments on tick_1hz while in an edit state.
  - When an increment reaches EDIT_TIMEOUT_S, the FSM takes the abort path on the next cycle (state, abort_p).
  - If an accepted pulse coincides with the tick, the pulse wins: the counter clears and no abort occurs.
- Ring logic:
  - A rising edge of alarm_hit sets ring=1 and clears the ring counter.
  - While ring=1, any button pulse clears ring and is consumed; state is unchanged and no edit pulse is produced.
  - ring also clears when the ring counter reaches RING_MAX_S ticks.
  - A fresh alarm_hit rising edge while ring=1 restarts the ring counter.
  - State transitions continue normally while ringing unless a pulse is consumed.
- Invalid state encodings do not exist: all 16 codes are legal.

Optional Feature:
Macro: CLOCK_MODE_AUTO_RETURN_EN.
- Defined: in DATE_DISP, ALARM_DISP or TIMER_DISP, AUTO_RET_S ticks with no accepted pulse return the FSM to TIME_DISP. abort_p does not fire. The idle counter is reused, sized to max(EDIT_TIMEOUT_S, AUTO_RET_S).
- Undefined: display states hold indefinitely, and AUTO_RET_S is unused.

Decomposition:
- Shared package `clock_pkg`: the 16 state localparams (TIME_DISP=0 … TIMER_EDIT_HOUR=15), plus a group-home function mapping an edit state to its display state.
- One sub-module, `sec_idle_timer`: a tick counter with clear, compare-to-limit, and a one-cycle `expired` output. It is instantiated once for idle timing and once for the ring limit.

Test Plan:
1. Reset, then mode_p ×4 -> state sequence 1, 8, 12, 0; no edit_up/edit_down/commit_p/abort_p asserted.
2. From TIME_DISP: set_p ×7 -> states 2, 3, 4, 5, 6, 7, 0; commit_p is high for exactly 1 cycle on the 7th set.
3. In state 10 (ALARM_EDIT_MINUTE): up_p, then down_p -> edit_up high 1 cycle, then edit_down high 1 cycle. A further up_p plus mode_p in the same cycle -> state 8, abort_p=1, edit_up=0.
4. In state 13: 30 tick_1hz with no pulses -> after the 30th tick state=12 and abort_p fires. Repeating with up_p on tick 29 -> no abort at tick 30.
5. alarm_hit 0->1 in state 4 -> ring=1. set_p -> ring=0, state stays 4. Repeating with no pulse -> ring drops after 60 ticks.
6. In state 5, assert rst for 1 ns mid-cycle -> state=0 and ring=0 immediately. With CLOCK_MODE_AUTO_RETURN_EN: in state 1, 10 ticks -> state 0, abort_p=0.
